// File: rtl/apb_master_arbiter.sv
// Round-robin APB master shared by NUM_REQ requesters. Runs SETUP/ACCESS with a
// PREADY watchdog and returns a one-cycle response pulse to the granted requester.
module apb_master_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SLV_COUNT  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                            PCLK,
  input  logic                            PRESET,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*SLV_COUNT-1:0]    req_sel,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic                            rsp_err,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic [ADDR_WIDTH-1:0]           PADDR,
  output logic                            PWRITE,
  output logic [SLV_COUNT-1:0]            PSEL,
  output logic                            PENABLE,
  output logic [DATA_WIDTH-1:0]           PWDATA,
  input  logic                            PREADY,
  input  logic [DATA_WIDTH-1:0]           PRDATA
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW:0] TO_LIMIT = (CW+1)'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state, state_d;
  logic [PW-1:0]           ptr, ptr_d;
  logic [CW-1:0]           cnt, cnt_d;
  logic [CW:0]             cnt_inc;
  logic                    timed_out;

  logic [PW-1:0]           lat_grant, lat_grant_d;
  logic                    lat_write, lat_write_d;
  logic [SLV_COUNT-1:0]    lat_sel, lat_sel_d;

  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic                    pwrite_d, penable_d;
  logic [SLV_COUNT-1:0]    psel_d;
  logic [DATA_WIDTH-1:0]   pwdata_d;
  logic [NUM_REQ-1:0]      rsp_valid_d;
  logic                    rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d;

  logic [PW-1:0]           grant;
  logic                    found;
  logic                    g_write;
  logic [SLV_COUNT-1:0]    g_sel;
  logic [ADDR_WIDTH-1:0]   g_addr;
  logic [DATA_WIDTH-1:0]   g_wdata;

  // Scan from the highest offset down so the nearest valid index at/after ptr wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        grant = PW'((int'(ptr) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

  assign g_write = req_write[grant];
  assign g_sel   = req_sel[int'(grant)*SLV_COUNT +: SLV_COUNT];
  assign g_addr  = req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
  assign g_wdata = req_wdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];

  assign cnt_inc   = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
  assign timed_out = (TIMEOUT != 0) && (cnt_inc >= TO_LIMIT);

  // NOTE: every signal is given a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    cnt_d       = cnt;
    lat_grant_d = lat_grant;
    lat_write_d = lat_write;
    lat_sel_d   = lat_sel;
    paddr_d     = PADDR;
    pwrite_d    = PWRITE;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    pwdata_d    = PWDATA;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    req_ready   = '0;

    unique case (state)
      IDLE: begin
        if (found) begin
          req_ready[grant] = 1'b1;
          lat_grant_d      = grant;
          lat_write_d      = g_write;
          lat_sel_d        = g_sel;
          ptr_d            = (grant == PW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          state_d          = SETUP;
          // A zero select never reaches the bus; the SETUP slot is spent idle.
          if (g_sel != '0) begin
            paddr_d  = g_addr;
            pwrite_d = g_write;
            psel_d   = g_sel;
            pwdata_d = g_write ? g_wdata : '0;
          end
        end
      end
      SETUP: begin
        if (lat_sel == '0) begin
          rsp_valid_d[lat_grant] = 1'b1;
          rsp_err_d              = 1'b1;
          state_d                = RESP;
        end else begin
          penable_d = 1'b1;
          cnt_d     = '0;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (PREADY || timed_out) begin
          paddr_d                = '0;
          pwrite_d               = 1'b0;
          psel_d                 = '0;
          penable_d              = 1'b0;
          pwdata_d               = '0;
          cnt_d                  = '0;
          rsp_valid_d[lat_grant] = 1'b1;
          rsp_err_d              = !PREADY;
          rsp_rdata_d            = (PREADY && !lat_write) ? PRDATA : '0;
          state_d                = RESP;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      lat_grant <= '0;
      lat_write <= 1'b0;
      lat_sel   <= '0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWDATA    <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      lat_grant <= lat_grant_d;
      lat_write <= lat_write_d;
      lat_sel   <= lat_sel_d;
      PADDR     <= paddr_d;
      PWRITE    <= pwrite_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWDATA    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: inputs change and outputs are sampled
// on the falling edge, half a cycle away from the active edge.
module tb_apb_master_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SC = 4;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic [NR-1:0]     req_valid, req_ready, req_write, rsp_valid;
  logic [NR*SC-1:0]  req_sel;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic              rsp_err, PWRITE, PENABLE, PREADY;
  logic [DW-1:0]     rsp_rdata, PWDATA, PRDATA;
  logic [AW-1:0]     PADDR;
  logic [SC-1:0]     PSEL;

  int checks = 0;
  int errors = 0;

  apb_master_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .SLV_COUNT(SC), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle: through the rising edge to the next falling edge.
  task automatic step();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  task automatic bus_idle(input string tag);
    check({tag, ".psel"},    64'(PSEL),    64'h0);
    check({tag, ".penable"}, 64'(PENABLE), 64'h0);
    check({tag, ".paddr"},   64'(PADDR),   64'h0);
    check({tag, ".pwdata"},  64'(PWDATA),  64'h0);
    check({tag, ".pwrite"},  64'(PWRITE),  64'h0);
  endtask

  task automatic set_req(input int i, input logic wr, input logic [SC-1:0] sel,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    req_write[i]            = wr;
    req_sel[i*SC +: SC]     = sel;
    req_addr[i*AW +: AW]    = addr;
    req_wdata[i*DW +: DW]   = wdata;
  endtask

  initial begin
    logic [NR-1:0] exp_g;
    PRESET    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_sel   = '0;
    req_addr  = '0;
    req_wdata = '0;
    PREADY    = 1'b0;
    PRDATA    = '0;
    @(negedge PCLK);
    step();
    PRESET = 1'b0;
    #1;
    bus_idle("reset");
    check("reset.rsp_valid", 64'(rsp_valid), 64'h0);
    check("reset.rsp_err",   64'(rsp_err),   64'h0);
    check("reset.rsp_rdata", 64'(rsp_rdata), 64'h0);
    check("reset.req_ready", 64'(req_ready), 64'h0);

    // Single write from req1, PREADY high in the first ACCESS cycle.
    set_req(1, 1'b1, 4'b0010, 32'h10, 32'hA5A5_0001);
    req_valid = 4'b0010;
    #1 check("wr.t0.ready", 64'(req_ready), 64'h2);
    step();
    req_valid = '0;
    PREADY    = 1'b1;
    #1;
    check("wr.t1.psel",    64'(PSEL),    64'h2);
    check("wr.t1.penable", 64'(PENABLE), 64'h0);
    check("wr.t1.paddr",   64'(PADDR),   64'h10);
    check("wr.t1.pwrite",  64'(PWRITE),  64'h1);
    check("wr.t1.pwdata",  64'(PWDATA),  64'hA5A5_0001);
    check("wr.t1.ready",   64'(req_ready), 64'h0);
    step();
    check("wr.t2.penable", 64'(PENABLE), 64'h1);
    check("wr.t2.psel",    64'(PSEL),    64'h2);
    check("wr.t2.rsp",     64'(rsp_valid), 64'h0);
    step();
    check("wr.t3.rsp_valid", 64'(rsp_valid), 64'h2);
    check("wr.t3.rsp_err",   64'(rsp_err),   64'h0);
    bus_idle("wr.t3");
    step();
    check("wr.t4.rsp_valid", 64'(rsp_valid), 64'h0);

    // Read from req0 with three wait states.
    PREADY = 1'b0;
    set_req(0, 1'b0, 4'b0001, 32'h20, 32'h1234_5678);
    req_valid = 4'b0001;
    #1 check("rd.t0.ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    #1;
    check("rd.t1.pwrite", 64'(PWRITE), 64'h0);
    check("rd.t1.pwdata", 64'(PWDATA), 64'h0);
    check("rd.t1.paddr",  64'(PADDR),  64'h20);
    for (int c = 2; c <= 4; c++) begin
      step();
      check($sformatf("rd.t%0d.penable", c), 64'(PENABLE), 64'h1);
      check($sformatf("rd.t%0d.rsp", c), 64'(rsp_valid), 64'h0);
    end
    step();
    PREADY = 1'b1;
    PRDATA = 32'hDEAD_BEEF;
    step();
    PREADY = 1'b0;
    PRDATA = '0;
    check("rd.t6.rsp_valid", 64'(rsp_valid), 64'h1);
    check("rd.t6.rsp_err",   64'(rsp_err),   64'h0);
    check("rd.t6.rsp_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    step();
    check("rd.t7.rsp_rdata", 64'(rsp_rdata), 64'h0);

    // Round-robin: all four requesters valid right after reset.
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, SC'(1 << i), AW'(32'h100 + i*4), '0);
    PREADY    = 1'b1;
    PRDATA    = 32'h0000_0055;
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_g = NR'(1 << (n % NR));
      #1 check($sformatf("rr%0d.ready", n), 64'(req_ready), 64'(exp_g));
      step();
      check($sformatf("rr%0d.psel", n), 64'(PSEL), 64'(exp_g));
      check($sformatf("rr%0d.ready_gap", n), 64'(req_ready), 64'h0);
      step();
      step();
      check($sformatf("rr%0d.rsp", n), 64'(rsp_valid), 64'(exp_g));
      check($sformatf("rr%0d.rdata", n), 64'(rsp_rdata), 64'h55);
      step();
    end
    req_valid = '0;
    PRDATA    = '0;
    step();

    // Timeout: req3 write, PREADY never rises.
    PREADY = 1'b0;
    set_req(3, 1'b1, 4'b1000, 32'h40, 32'h0BAD_0BAD);
    req_valid = 4'b1000;
    #1 check("to.t0.ready", 64'(req_ready), 64'h8);
    step();
    req_valid = '0;
    for (int c = 2; c <= 17; c++) step();
    check("to.t17.penable", 64'(PENABLE), 64'h1);
    check("to.t17.rsp",     64'(rsp_valid), 64'h0);
    step();
    check("to.t18.rsp_valid", 64'(rsp_valid), 64'h8);
    check("to.t18.rsp_err",   64'(rsp_err),   64'h1);
    check("to.t18.rsp_rdata", 64'(rsp_rdata), 64'h0);
    bus_idle("to.t18");
    step();

    // Bad select: req2 with sel = 0 never touches the bus.
    set_req(2, 1'b0, 4'b0000, 32'h80, '0);
    req_valid = 4'b0100;
    #1 check("bs.t0.ready", 64'(req_ready), 64'h4);
    step();
    req_valid = '0;
    #1;
    bus_idle("bs.t1");
    check("bs.t1.rsp", 64'(rsp_valid), 64'h0);
    step();
    check("bs.t2.rsp_valid", 64'(rsp_valid), 64'h4);
    check("bs.t2.rsp_err",   64'(rsp_err),   64'h1);
    check("bs.t2.psel",      64'(PSEL),      64'h0);
    step();
    check("bs.t3.rsp_valid", 64'(rsp_valid), 64'h0);

    // Reset in the middle of ACCESS aborts the transfer and rewinds the pointer.
    set_req(1, 1'b1, 4'b0010, 32'h14, 32'h7777_0000);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    check("rst.t2.penable", 64'(PENABLE), 64'h1);
    PRESET = 1'b1;
    step();
    bus_idle("rst.t3");
    check("rst.t3.rsp", 64'(rsp_valid), 64'h0);
    PRESET = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("rst.quiet%0d.rsp", c), 64'(rsp_valid), 64'h0);
    end
    set_req(0, 1'b0, 4'b0001, 32'h24, '0);
    set_req(3, 1'b0, 4'b1000, 32'h4C, '0);
    PREADY    = 1'b1;
    req_valid = 4'b1001;
    #1 check("rst.ptr.ready", 64'(req_ready), 64'h1);
    step();
    req_valid = 4'b1000;
    check("rst.ptr.psel", 64'(PSEL), 64'h1);
    step();
    step();
    check("rst.ptr.rsp", 64'(rsp_valid), 64'h1);
    step();
    #1 check("rst.next.ready", 64'(req_ready), 64'h8);
    step();
    req_valid = '0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
Multi-requester APB master that shares one APB bus among NUM_REQ internal requesters (sequences, test agents, DMA-like sources). It arbitrates round-robin, runs the SETUP/ACCESS phases, waits on PREADY with a watchdog, and returns read data or error per requester. It drives the master side of the APB interface and returns all master signals to zero when idle.

Parameters:
NUM_REQ, 4, number of requesters
ADDR_WIDTH, 32, PADDR width
DATA_WIDTH, 32, PWDATA/PRDATA width
SLV_COUNT, 4, PSEL width (one bit per slave)
TIMEOUT, 16, max ACCESS cycles waiting for PREADY; 0 disables the watchdog

Ports:
PCLK  in  1  clock
PRESET  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  request pending, per requester
req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
req_write  in  NUM_REQ  1=write, 0=read
req_sel  in  NUM_REQ*SLV_COUNT  target PSEL vector, requester i at [i*SLV_COUNT +: SLV_COUNT]
req_addr  in  NUM_REQ*ADDR_WIDTH  address, same packing
req_wdata  in  NUM_REQ*DATA_WIDTH  write data, same packing
rsp_valid  out  NUM_REQ  one-cycle completion pulse to the granted requester
rsp_err  out  1  error qualifier for rsp_valid (bad sel or timeout)
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
PADDR  out  ADDR_WIDTH  APB address
PWRITE  out  1  APB direction
PSEL  out  SLV_COUNT  APB slave select
PENABLE  out  1  APB enable
PWDATA  out  DATA_WIDTH  APB write data
PREADY  in  1  slave ready
PRDATA  in  DATA_WIDTH  slave read data

Behaviour:
- FSM: IDLE, SETUP, ACCESS, RESP. All outputs registered except req_ready (combinational from IDLE state and arbiter).
- Reset (PRESET high at posedge): state IDLE; PADDR, PWRITE, PSEL, PENABLE, PWDATA, rsp_valid, rsp_err, rsp_rdata = 0; RR pointer = 0; timeout counter = 0. Reset mid-transfer aborts the transfer with no response; the bus returns to zero at the next edge.
- IDLE: if any req_valid, grant g = first valid index at or after the RR pointer (wrapping); req_ready[g]=1 this cycle; latch write/sel/addr/wdata of g; RR pointer <= (g+1) mod NUM_REQ; next state SETUP. req_ready is 0 in all other states.
- Latched sel == 0: skip the bus, go to RESP with rsp_err=1. A non-zero sel is driven as-is; requesters supply one-hot.
- SETUP (1 cycle): PSEL=sel, PADDR, PWRITE, PWDATA (0 for reads) driven, PENABLE=0; next state ACCESS.
- ACCESS: PENABLE=1, other signals held. Counter increments each cycle. On a posedge with PREADY=1: capture PRDATA (reads only, else 0) and go to RESP with err=0. If TIMEOUT!=0 and counter reaches TIMEOUT with PREADY low: go to RESP with err=1 and rdata=0.
- RESP (1 cycle): all APB outputs 0; rsp_valid[g]=1, rsp_err, rsp_rdata valid; next state IDLE. rsp_valid, rsp_err, and rsp_rdata are 0 in other cycles.
- Minimum latency from accept to rsp_valid: 3 cycles (SETUP, ACCESS with PREADY=1, RESP). Back-to-back transfers are separated by one IDLE cycle; PSEL drops between transfers.
- Requester contract: hold req_* stable while req_valid=1 until req_ready. A requester may deassert valid before grant without effect.
- Simultaneous valids: strict round-robin; no requester waits more than NUM_REQ-1 grants.

Test Plan:
- Single write: req1 valid, write, sel=4'b0010, addr=0x10, wdata=0xA5A5_0001, PREADY=1 in the first ACCESS cycle -> req_ready[1] at t0; SETUP t1 with PSEL=0010, PENABLE=0; ACCESS t2 with PENABLE=1; rsp_valid[1] at t3 with err=0; bus all-zero at t3.
- Read with wait states: req0 read, addr=0x20, PREADY low 3 ACCESS cycles, then high with PRDATA=0xDEAD_BEEF -> rsp_rdata=0xDEAD_BEEF, rsp_valid[0] 6 cycles after accept.
- Round-robin: all 4 valid continuously after reset -> grant order 0,1,2,3,0; each grant 4 cycles apart with PREADY=1.
- Timeout: TIMEOUT=16, PREADY stuck low -> after 16 ACCESS cycles, rsp_valid with rsp_err=1 and rsp_rdata=0; PSEL/PENABLE drop to 0.
- Bad select: req2 with sel=0 -> no PSEL activity; rsp_valid[2] and rsp_err=1 two cycles after accept.
- Reset mid-ACCESS: assert PRESET during ACCESS -> next edge all outputs 0, no rsp_valid; next request from req3 alongside req0 grants req0 first (pointer reset).
